// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage. Owns the HI/LO registers,
// runs one radix-2 step per cycle and holds busy while an operation is in flight.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_bmag;
  logic [WIDTH-1:0]   r_a_orig;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div_zero;
  logic               r_done;

  logic               w_idle_go;
  logic               w_mdiv_start;
  logic               w_signed;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_rem_sub;
  logic               w_rem_ge;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  // abort in IDLE suppresses any same-cycle start, including MTHI/MTLO
  assign w_idle_go    = start && !abort && (r_state == IDLE);
  assign w_mdiv_start = w_idle_go && !op[2];
  assign w_signed     = !op[0];
  assign w_a_mag      = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_mag      = (w_signed && b[WIDTH-1]) ? -b : b;

  // Shared accumulator: upper half is partial product / remainder,
  // lower half is multiplier / dividend shifting out as quotient shifts in.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_bmag} : '0);
  assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_rem_ge  = w_rem_sh >= {1'b0, r_bmag};
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_bmag;

  always_comb begin
    w_step = {w_mul_sum, r_acc[WIDTH-1:1]};
    if (r_is_div)
      w_step = {(w_rem_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_rem_ge};
  end

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_mdiv_start) w_next = CALC;
      CALC:    if (abort) w_next = IDLE;
               else if (r_cnt == LAST) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_bmag     <= '0;
      r_a_orig   <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_done     <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      r_done <= (r_state == FIX) && !abort;
      case (r_state)
        IDLE: begin
          if (w_mdiv_start) begin
            r_cnt      <= '0;
            r_acc      <= {{WIDTH{1'b0}}, w_a_mag};
            r_bmag     <= w_b_mag;
            r_a_orig   <= a;
            r_is_div   <= op[1];
            r_neg_q    <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r    <= w_signed && a[WIDTH-1];
            r_div_zero <= op[1] && (b == '0);
          end
          if (w_idle_go && op == 3'b100) hi <= a;
          if (w_idle_go && op == 3'b101) lo <= a;
        end
        CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 1'b1;
        end
        FIX: begin
          if (!abort) begin
            if (!r_is_div) begin
              hi <= w_prod[2*WIDTH-1:WIDTH];
              lo <= w_prod[WIDTH-1:0];
            end else if (r_div_zero) begin
              hi <= r_a_orig;
              lo <= '1;
            end else begin
              hi <= w_rem;
              lo <= w_quo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: scoreboard of expected HI/LO pushed at issue
// and popped when done pulses, plus reset, move-to, abort and back-to-back scenarios.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];

  ex_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .abort(abort), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference result as {hi, lo}, from native SystemVerilog arithmetic.
  function automatic logic [63:0] model(input logic [2:0] mop, input logic [31:0] ma,
                                        input logic [31:0] mb);
    logic signed [31:0] sa;
    logic signed [31:0] sbv;
    logic signed [63:0] p;
    sa  = ma;
    sbv = mb;
    case (mop)
      3'b000: begin p = 64'(sa) * 64'(sbv); return p; end
      3'b001: return {32'h0, ma} * {32'h0, mb};
      3'b010: begin
        if (mb == 0) return {ma, 32'hFFFF_FFFF};
        if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sbv), 32'(sa / sbv)};
      end
      3'b011: begin
        if (mb == 0) return {ma, 32'hFFFF_FFFF};
        return {ma % mb, ma / mb};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Issues a mul/div in the current cycle T and returns in the done cycle.
  task automatic issue(input string name, input logic [2:0] iop, input logic [31:0] ia,
                       input logic [31:0] ib);
    int k;
    int busy_cnt;
    logic [63:0] exp;
    sb.push_back(model(iop, ia, ib));
    start = 1'b1; op = iop; a = ia; b = ib;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_T+1: got %b want 1", name, busy);
    end
    k = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && k < 100) begin
      if (busy === 1'b1) busy_cnt++;
      step();
      k++;
    end
    checks++;
    if (k != 34) begin
      errors++;
      $display("FAIL %s done_cycle: got T+%0d want T+34", name, k);
    end
    checks++;
    if (busy_cnt != 33 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_len: got %0d (busy now %b) want 33 (0)", name, busy_cnt, busy);
    end
    exp = sb.pop_front();
    checks++;
    if ({hi, lo} !== exp) begin
      errors++;
      $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo,
               exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0; op = 3'b000; a = '0; b = '0; abort = 1'b0;
    step();
    checks++;
    if ({busy, done, hi, lo} !== 66'h0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
    end
    reset = 1'b1;
    step();
    start = 1'b1; op = 3'b100; a = 32'hAAAA_5555;
    step();
    op = 3'b000; a = 32'd1234; b = 32'd5678;
    step();
    start = 1'b0;
    repeat (10) step();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, hi, lo} !== 65'h0) begin
      errors++;
      $display("FAIL reset_midcalc: got busy=%b hi=%h lo=%h want 0", busy, hi, lo);
    end
    step();
    reset = 1'b1;
    step();
    issue("reset_multu5x7", 3'b001, 32'd5, 32'd7);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h23) begin
      errors++;
      $display("FAIL reset_multu_const: got hi=%h lo=%h want 0/23", hi, lo);
    end
  endtask

  task automatic test_mul();
    step();
    issue("mult_neg2x3", 3'b000, 32'hFFFF_FFFE, 32'd3);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_const: got hi=%h lo=%h want ffffffff/fffffffa", hi, lo);
    end
    step();
    issue("multu_fffe_x3", 3'b001, 32'hFFFF_FFFE, 32'd3);
    checks++;
    if (hi !== 32'h2 || lo !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL multu_const: got hi=%h lo=%h want 00000002/fffffffa", hi, lo);
    end
    step();
    issue("mult_rand", 3'b000, $urandom, $urandom);
    step();
    issue("multu_rand", 3'b001, $urandom, $urandom);
  endtask

  task automatic test_div();
    step();
    issue("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_const: got hi=%h lo=%h want ffffffff/fffffffd", hi, lo);
    end
    step();
    issue("div_overflow", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    step();
    issue("divu_by_zero", 3'b011, 32'd100, 32'd0);
    step();
    issue("div_7_m3", 3'b010, 32'd7, 32'hFFFF_FFFD);
    step();
    issue("divu_rand", 3'b011, $urandom, $urandom_range(1, 65535));
  endtask

  task automatic test_move_to();
    logic [31:0] hold_lo;
    step();
    hold_lo = lo;
    start = 1'b1; op = 3'b100; a = 32'h1234_5678;
    step();
    checks++;
    if (hi !== 32'h1234_5678 || lo !== hold_lo || busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi: got hi=%h lo=%h busy=%b want 12345678/%h/0", hi, lo, busy, hold_lo);
    end
    op = 3'b101; a = 32'hCAFE_BABE;
    step();
    checks++;
    if (hi !== 32'h1234_5678 || lo !== 32'hCAFE_BABE || busy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo: got hi=%h lo=%h busy=%b want 12345678/cafebabe/0", hi, lo, busy);
    end
    op = 3'b011; a = 32'd9; b = 32'd2; abort = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || hi !== 32'h1234_5678 || lo !== 32'hCAFE_BABE) begin
      errors++;
      $display("FAIL abort_start: got busy=%b hi=%h lo=%h want 0/12345678/cafebabe", busy, hi, lo);
    end
    op = 3'b100; a = 32'hDEAD_0000;
    step();
    checks++;
    if (hi !== 32'h1234_5678) begin
      errors++;
      $display("FAIL abort_mthi: got hi=%h want 12345678", hi);
    end
    start = 1'b0; abort = 1'b0; op = 3'b110;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h1234_5678 || lo !== 32'hCAFE_BABE) begin
      errors++;
      $display("FAIL noop_110: got busy=%b hi=%h lo=%h", busy, hi, lo);
    end
  endtask

  // Starts a MULT and aborts it in cycle T+at; HI/LO must hold and done never fire.
  task automatic abort_at(input string name, input int at);
    logic [31:0] h0;
    logic [31:0] l0;
    int seen;
    step();
    h0 = hi; l0 = lo;
    start = 1'b1; op = 3'b000; a = 32'd77; b = 32'd99;
    step();
    start = 1'b0;
    repeat (at - 1) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_next: got busy=%b want 0", name, busy);
    end
    seen = 0;
    repeat (40) begin
      if (done === 1'b1) seen++;
      step();
    end
    checks++;
    if (seen != 0 || hi !== h0 || lo !== l0) begin
      errors++;
      $display("FAIL %s hold: got done_pulses=%0d hi=%h lo=%h want 0/%h/%h", name, seen,
               hi, lo, h0, l0);
    end
  endtask

  task automatic test_back_to_back();
    step();
    issue("b2b_first_divu", 3'b011, 32'd1000, 32'd7);
    issue("b2b_second_multu", 3'b001, 32'h0001_0001, 32'h0000_FFFF);
    issue("b2b_third_div", 3'b010, 32'hFFFF_FF00, 32'd16);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_move_to();
    abort_at("abort_calc20", 20);
    abort_at("abort_fix", 33);
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage, consuming the operands and control held in the ID/EX pipeline register. It executes MULT/MULTU/DIV/DIVU over multiple cycles, owns the architectural HI/LO registers, and raises `busy` so the hazard unit can stall IF/ID and ID/EX while an operation is in flight. MFHI/MFLO read `hi`/`lo` directly.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; the iteration counter is `$clog2(WIDTH)` bits wide.
- `clk`  in  1  pipeline clock.
- `reset`  in  1  asynchronous, active-low reset. One clock domain; the polarity and synchronicity are fixed.
- `start`  in  1  a mul/div/move-to op is valid in EX this cycle.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- `a`  in  WIDTH  rs operand after forwarding.
- `b`  in  WIDTH  rt operand after forwarding.
- `abort`  in  1  cancel the in-flight operation (exception/flush of the owning instruction).
- `busy`  out  1  operation in flight; hazard unit stalls EX consumers of HI/LO and new `start`.
- `done`  out  1  one-cycle pulse: new HI/LO result is visible this cycle.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - `start` with MULT/MULTU/DIV/DIVU latches the operands and goes to CALC with counter = 0.
  - Signed ops latch |a| and |b| and record the quotient/product sign (a^b) and the remainder sign (a).
  - MTHI writes `hi`=`a`; MTLO writes `lo`=`a`. These complete in IDLE; `busy` never asserts.
  - Ops 110/111 do nothing.
- CALC: one iteration per cycle for WIDTH cycles; leaves when counter = WIDTH-1.
  - Multiply: radix-2 shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract, 1 quotient bit per cycle.
- FIX: one cycle.
  - Apply the two's-complement sign fix for signed ops: product sign to the product; quotient sign to LO; remainder sign to HI.
  - Write HI/LO: multiply HI=upper, LO=lower; divide LO=quotient, HI=remainder.
  - Return to IDLE and set `done`.
- Divide by zero (DIV or DIVU): HI=`a` (original, unsigned-magnitude path not sign-fixed), LO=all ones. No trap.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude path naturally.
- `start` while `busy`: ignored; the hazard unit guarantees it is held stalled.
- `abort` in CALC/FIX: return to IDLE at the next edge; HI/LO are unchanged and `done` is not pulsed.
- `abort` in IDLE suppresses a same-cycle `start`, including MTHI/MTLO. `abort` has priority over FIX completion.
- Reset (any time, including mid-operation):
  - State returns to IDLE and the counter clears.
  - `hi`=0, `lo`=0, `busy`=0, `done`=0.
  - Latched operands clear to 0.

## Timing
- Mul/div `start` sampled at the edge ending cycle T:
  - `busy`=1 in cycles T+1..T+WIDTH+1. For WIDTH=32 this is 33 cycles: 32 CALC + 1 FIX.
  - New `hi`/`lo` and `done`=1 are visible in cycle T+WIDTH+2. `busy`=0 in that cycle.
- MTHI/MTLO at cycle T: the new value is visible in T+1.
- `busy` is a registered output, high exactly while the state is CALC or FIX.
- `done` is registered, high for one cycle only.
- `hi`/`lo` are registered outputs with no combinational path from `a`/`b`.
- A new `start` is accepted in the same cycle `done` is high (state is IDLE), giving back-to-back ops with no dead cycle.

## Test plan
- Reset: drive `reset`=0 mid-CALC of a MULT.
  - Required: `busy`=0 immediately (asynchronous); `hi`=`lo`=0.
  - After release, a fresh MULTU 5×7 gives LO=0x23, HI=0 at T+34.
- MULT `a`=0xFFFFFFFE, `b`=3: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MULTU with the same operands: HI=0x00000002, LO=0xFFFFFFFA.
  - For both: `busy` high exactly 33 cycles; `done` in T+34.
- DIV -7/2 (`a`=0xFFFFFFF9, `b`=2): LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU 100/0: HI=0x00000064, LO=0xFFFFFFFF; `done` at T+34.
- MTHI 0x12345678, then MTLO 0xCAFEBABE on consecutive cycles: `hi`/`lo` update one cycle after each; `busy` stays 0.
  - Then `start` DIVU with `abort`=1 in the same cycle: no state change.
- Abort and back-to-back:
  - `abort` at cycle 20 of a MULT: IDLE next cycle, HI/LO hold prior values, no `done`.
  - A MULTU issued in the `done` cycle of a previous op: accepted, `busy` asserts the next cycle.
